// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - DMSel codes, responder FSM states and alignment helper
package dm_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } dm_state_e;

  function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] addr_lo);
    case (sel)
      DM_W:        return addr_lo != 2'b00;
      DM_H, DM_HU: return addr_lo[0];
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - store lane merge and load lane extraction/extension
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_word_o,
  output logic [31:0] load_ext_o,
  output logic        misaligned_o
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  assign half_v       = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
  assign byte_v       = old_word_i[{addr_lo_i, 3'b000} +: 8];
  assign misaligned_o = is_misaligned(sel_i, addr_lo_i);

  // Reserved selects leave the word untouched and load zero; the top flags them.
  always_comb begin
    merged_word_o = old_word_i;
    load_ext_o    = '0;
    case (sel_i)
      DM_W: begin
        merged_word_o = wdata_i;
        load_ext_o    = old_word_i;
      end
      DM_H, DM_HU: begin
        if (addr_lo_i[1]) merged_word_o[31:16] = wdata_i[15:0];
        else              merged_word_o[15:0]  = wdata_i[15:0];
        load_ext_o = {{16{(sel_i == DM_H) & half_v[15]}}, half_v};
      end
      DM_B, DM_BU: begin
        merged_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        load_ext_o = {{24{(sel_i == DM_B) & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - multi-cycle data-memory responder with request/response handshakes
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] Exam_RAM_D
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  dm_state_e   state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [2:0]  sel_q;
  logic [31:0] addr_q, wdata_q;
  logic        req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, exam_q;

  logic [31:0] old_word, merged_word, load_ext;
  logic        misaligned, out_of_range, bad_sel, acc_err, do_access, mem_we;

  assign old_word     = mem[addr_q[AW+1:2]];
  assign out_of_range = addr_q[31:2] >= 30'(DEPTH);
  assign bad_sel      = sel_q > DM_BU;
  assign acc_err      = misaligned | out_of_range | bad_sel;
  assign do_access    = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign mem_we       = do_access && we_q && !acc_err;
  assign rsp_rdata_d  = (we_q || acc_err) ? 32'd0 : load_ext;

  dm_lane_align u_align (
    .sel_i         (sel_q),
    .addr_lo_i     (addr_q[1:0]),
    .old_word_i    (old_word),
    .wdata_i       (wdata_q),
    .merged_word_o (merged_word),
    .load_ext_o    (load_ext),
    .misaligned_o  (misaligned)
  );

  // The array has no reset; an async reset forces IDLE so a pending store never lands.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q[AW+1:2]] <= merged_word;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= DM_W;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      exam_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          we_q        <= req_we;
          sel_q       <= req_sel;
          addr_q      <= req_addr;
          wdata_q     <= req_wdata;
          cnt_q       <= CNT_INIT;
          req_ready_q <= 1'b0;
          state_q     <= S_BUSY;
        end
        S_BUSY: if (cnt_q == 4'd0) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rsp_rdata_d;
          rsp_err_q   <= acc_err;
          if (mem_we) exam_q <= merged_word;
          state_q     <= S_RESP;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign Exam_RAM_D = exam_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed self-checking bench with byte-level memory model
module tb_dm_responder;
  import dm_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exam;
  } rsp_t;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_sel   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [31:0] exam      [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat [2] = '{2, 1};

  logic [7:0]  mb [2][4*DEPTH];
  logic [31:0] exam_m [2];
  rsp_t        q0 [$];
  rsp_t        q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dm_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
    .clk(clk), .RESET_N(RESET_N),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_sel(req_sel[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .Exam_RAM_D(exam[0])
  );

  dm_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .RESET_N(RESET_N),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_sel(req_sel[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .Exam_RAM_D(exam[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Memory as a little-endian byte array; access size and sign come straight from sel.
  function automatic rsp_t model(input int d, input bit we, input logic [2:0] sel,
                                 input logic [31:0] addr, input logic [31:0] wd);
    rsp_t r;
    int size;
    logic [31:0] v, base;
    size = (sel == 3'd0) ? 4 : (sel == 3'd1 || sel == 3'd2) ? 2 :
           (sel == 3'd3 || sel == 3'd4) ? 1 : 0;
    r.rdata = 32'd0;
    r.err   = 1'b0;
    r.exam  = exam_m[d];
    if (size == 0) r.err = 1'b1;
    else if ((addr % 32'(size)) != 0 || addr >= 32'(4*DEPTH)) r.err = 1'b1;
    if (!r.err && we) begin
      for (int b = 0; b < size; b++) mb[d][addr + 32'(b)] = wd[8*b +: 8];
      base = addr & ~32'd3;
      exam_m[d] = {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
      r.exam = exam_m[d];
    end else if (!r.err) begin
      v = 32'd0;
      for (int b = 0; b < size; b++) v = v | (32'(mb[d][addr + 32'(b)]) << (8*b));
      if ((sel == DM_H || sel == DM_B) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      r.rdata = v;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (RESET_N) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 required 0", d);
          end else begin
            rsp_t e;
            e = (d == 0) ? q0[0] : q1[0];
            chk("rsp_rdata", rsp_rdata[d], e.rdata);
            chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
            chk("exam_ram_d", exam[d], e.exam);
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    if (RESET_N) begin
      if (rsp_valid[0] && rsp_ready[0] && q0.size() > 0) void'(q0.pop_front());
      if (rsp_valid[1] && rsp_ready[1] && q1.size() > 0) void'(q1.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge after the response handshake.
  task automatic xfer(input int d, input bit we, input logic [2:0] sel, input logic [31:0] addr,
                      input logic [31:0] wd, input int hold, output logic [31:0] rd,
                      output logic er, output logic [31:0] ex, output int occ);
    rsp_t e;
    int n, acc;
    e = model(d, we, sel, addr, wd);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    rsp_ready[d] = (hold == 0);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_sel[d]   = sel;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc          = cyc;
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    n = 0;
    while (!rsp_valid[d] && n < 40) begin @(negedge clk); n++; end
    chk("rsp_latency", 32'(n), 32'(lat[d]));
    rd = rsp_rdata[d];
    er = rsp_err[d];
    ex = exam[d];
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = (i % 2 == 0);
      req_addr[d]  = $urandom;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], rd);
      chk("hold_err", 32'(rsp_err[d]), 32'(er));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    occ = cyc - acc;
    chk("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
    chk("post_hs_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    if (hold == 0) chk("occupancy", 32'(occ), 32'(lat[d] + 1));
  endtask

  initial begin
    logic [31:0] rd, ex;
    logic        er;
    int          occ;
    RESET_N = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_sel[d] = DM_W;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b1;
      exam_m[d] = 32'd0;
    end
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset_req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset_rdata", rsp_rdata[0], 32'd0);
    chk("reset_err", 32'(rsp_err[0]), 32'd0);
    chk("reset_exam", exam[0], 32'd0);
    @(negedge clk);
    RESET_N = 1'b1;
    @(negedge clk);

    // word store then load
    xfer(0, 1'b1, DM_W, 32'h8, 32'h1234_5678, 0, rd, er, ex, occ);
    chk("sw_exam", ex, 32'h1234_5678);
    xfer(0, 1'b0, DM_W, 32'h8, 32'h0, 0, rd, er, ex, occ);
    chk("lw_rdata", rd, 32'h1234_5678);

    // reset while a store is in BUSY
    xfer(0, 1'b1, DM_W, 32'h10, 32'h0BAD_F00D, 0, rd, er, ex, occ);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_sel[0] = DM_W;
    req_addr[0] = 32'h10; req_wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("busy_req_ready", 32'(req_ready[0]), 32'd0);
    RESET_N = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("async_req_ready", 32'(req_ready[0]), 32'd1);
    chk("async_exam", exam[0], 32'd0);
    exam_m[0] = 32'd0;
    exam_m[1] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    RESET_N = 1'b1;
    @(negedge clk);
    xfer(0, 1'b0, DM_W, 32'h10, 32'h0, 0, rd, er, ex, occ);
    chk("reset_discard_store", rd, 32'h0BAD_F00D);

    // byte/half lanes
    xfer(0, 1'b1, DM_W, 32'h0, 32'h1122_3344, 0, rd, er, ex, occ);
    xfer(0, 1'b1, DM_B, 32'h2, 32'h0000_00AB, 0, rd, er, ex, occ);
    chk("sb_exam", ex, 32'h11AB_3344);
    xfer(0, 1'b0, DM_B, 32'h2, 32'h0, 0, rd, er, ex, occ);
    chk("lb", rd, 32'hFFFF_FFAB);
    xfer(0, 1'b0, DM_BU, 32'h2, 32'h0, 0, rd, er, ex, occ);
    chk("lbu", rd, 32'h0000_00AB);
    xfer(0, 1'b0, DM_H, 32'h2, 32'h0, 0, rd, er, ex, occ);
    chk("lh", rd, 32'h0000_11AB);
    xfer(0, 1'b0, DM_W, 32'h0, 32'h0, 0, rd, er, ex, occ);
    chk("merged_word", rd, 32'h11AB_3344);

    // error cases
    xfer(0, 1'b0, DM_W, 32'h6, 32'h0, 0, rd, er, ex, occ);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    xfer(0, 1'b1, DM_H, 32'h3, 32'hFFFF_FFFF, 0, rd, er, ex, occ);
    chk("sh_mis_err", 32'(er), 32'd1);
    chk("sh_mis_exam", ex, 32'h11AB_3344);
    xfer(0, 1'b1, DM_W, 32'(DEPTH*4), 32'hFFFF_FFFF, 0, rd, er, ex, occ);
    chk("sw_oor_err", 32'(er), 32'd1);
    chk("sw_oor_exam", ex, 32'h11AB_3344);
    xfer(0, 1'b0, 3'b111, 32'h0, 32'h0, 0, rd, er, ex, occ);
    chk("bad_sel_err", 32'(er), 32'd1);
    chk("bad_sel_rdata", rd, 32'd0);
    xfer(0, 1'b0, DM_W, 32'h0, 32'h0, 0, rd, er, ex, occ);
    chk("err_mem_intact", rd, 32'h11AB_3344);

    // backpressure
    xfer(0, 1'b0, DM_W, 32'h8, 32'h0, 5, rd, er, ex, occ);
    chk("bp_rdata", rd, 32'h1234_5678);
    xfer(0, 1'b0, DM_HU, 32'h0, 32'h0, 3, rd, er, ex, occ);
    chk("bp_lhu", rd, 32'h0000_3344);

    // LATENCY=1 back-to-back
    xfer(1, 1'b1, DM_W, 32'h20, 32'hCAFE_F00D, 0, rd, er, ex, occ);
    chk("l1_sw_occ", 32'(occ), 32'd2);
    xfer(1, 1'b0, DM_W, 32'h20, 32'h0, 0, rd, er, ex, occ);
    chk("l1_lw_occ", 32'(occ), 32'd2);
    chk("l1_lw_rdata", rd, 32'hCAFE_F00D);

    @(negedge clk);
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
